// File: rtl/seq_divider_32by16.sv
// Sequential radix-2 restoring divider: 2*WIDTH-bit dividend / WIDTH-bit divisor -> WIDTH-bit quotient and remainder.
// Optional signed mode under `define DIV_SIGNED_EN (adds is_signed and a SIGNFIX state on the normal path).
module seq_divider_32by16 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
`ifdef DIV_SIGNED_EN
    input  logic               is_signed,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero,
    output logic               overflow
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, SIGNFIX, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]   rem, qshift, dvs, dlo;
    logic [CW-1:0]      count;
    logic               dbz_pend, ovf_pend;
    logic [WIDTH-1:0]   q_out, r_out;
    logic               dbz_out, ovf_out;

    logic               accept, err_pend, last;
    logic [2*WIDTH-1:0] dd_mag;
    logic [WIDTH-1:0]   dv_mag;
    logic [WIDTH:0]     trial, diff;
    logic               take;

    assign accept   = in_valid && in_ready;
    assign err_pend = dbz_pend || ovf_pend;
    assign last     = (count == CW'(WIDTH));

`ifdef DIV_SIGNED_EN
    logic             dd_neg, dv_neg;
    logic             smode, qneg, rneg;
    logic [WIDTH-1:0] q_signed, r_signed;
    logic             sgn_ovf;

    assign dd_neg = is_signed & dividend[2*WIDTH-1];
    assign dv_neg = is_signed & divisor[WIDTH-1];
    assign dd_mag = dd_neg ? -dividend : dividend;
    assign dv_mag = dv_neg ? -divisor : divisor;

    assign q_signed = qneg ? -qshift : qshift;
    assign r_signed = rneg ? -rem : rem;
    // A negative quotient may reach magnitude 2^(W-1); a positive one may not.
    assign sgn_ovf  = smode & (qneg ? (qshift > {1'b1, {(WIDTH-1){1'b0}}}) : qshift[WIDTH-1]);
`else
    assign dd_mag = dividend;
    assign dv_mag = divisor;
`endif

    assign trial = {rem, qshift[WIDTH-1]};
    assign diff  = trial - {1'b0, dvs};
    assign take  = (trial >= {1'b0, dvs});

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN: begin
                if (err_pend) begin
                    state_nxt = DONE;
                end else if (last) begin
`ifdef DIV_SIGNED_EN
                    state_nxt = SIGNFIX;
`else
                    state_nxt = DONE;
`endif
                end
            end
            SIGNFIX: state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = rst_n;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem      <= '0;
            qshift   <= '0;
            dvs      <= '0;
            dlo      <= '0;
            count    <= '0;
            dbz_pend <= 1'b0;
            ovf_pend <= 1'b0;
            q_out    <= '0;
            r_out    <= '0;
            dbz_out  <= 1'b0;
            ovf_out  <= 1'b0;
`ifdef DIV_SIGNED_EN
            smode    <= 1'b0;
            qneg     <= 1'b0;
            rneg     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (accept) begin
                    rem      <= dd_mag[2*WIDTH-1:WIDTH];
                    qshift   <= dd_mag[WIDTH-1:0];
                    dvs      <= dv_mag;
                    dlo      <= dividend[WIDTH-1:0];
                    count    <= '0;
                    dbz_pend <= (divisor == '0);
                    ovf_pend <= (divisor != '0) && (dd_mag[2*WIDTH-1:WIDTH] >= dv_mag);
`ifdef DIV_SIGNED_EN
                    smode    <= is_signed;
                    qneg     <= dd_neg ^ dv_neg;
                    rneg     <= dd_neg;
`endif
                end
                RUN: begin
                    if (err_pend) begin
                        q_out   <= '1;
                        r_out   <= dlo;
                        dbz_out <= dbz_pend;
                        ovf_out <= !dbz_pend;
                    end else if (!last) begin
                        // rem < dvs holds here, so diff always fits in WIDTH bits.
                        rem    <= take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
                        qshift <= {qshift[WIDTH-2:0], take};
                        count  <= count + 1'b1;
                    end else begin
`ifndef DIV_SIGNED_EN
                        q_out   <= qshift;
                        r_out   <= rem;
                        dbz_out <= 1'b0;
                        ovf_out <= 1'b0;
`endif
                    end
                end
`ifdef DIV_SIGNED_EN
                SIGNFIX: begin
                    q_out   <= sgn_ovf ? '1 : q_signed;
                    r_out   <= sgn_ovf ? dlo : r_signed;
                    dbz_out <= 1'b0;
                    ovf_out <= sgn_ovf;
                end
`endif
                default: ;
            endcase
        end
    end

    assign quotient    = q_out;
    assign remainder   = r_out;
    assign div_by_zero = dbz_out;
    assign overflow    = ovf_out;
endmodule

// File: tb/tb_seq_divider_32by16.sv
// Directed-vector bench for seq_divider_32by16.
module tb_seq_divider_32by16;
`ifdef DIV_SIGNED_EN
    localparam int NLAT = 18;
`else
    localparam int NLAT = 17;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
`ifdef DIV_SIGNED_EN
    logic        is_signed = 1'b0;
`endif
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] quotient, remainder;
    logic        div_by_zero, overflow;

    int pass_cnt = 0;
    int total_cnt = 0;

    seq_divider_32by16 #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
`ifdef DIV_SIGNED_EN
        .is_signed  (is_signed),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Present one operation so it is taken on the next rising edge, then scramble the operands.
    task automatic start_op(input logic [31:0] dd, input logic [15:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = ~dd;
        divisor  = ~dv;
    endtask

    // Edges from accept until out_valid is first seen; 999 if it never appears.
    task automatic wait_result(output int lat);
        lat = 999;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b want=0", in_ready); else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_by_zero, overflow} !== 34'h0)
            $display("FAIL reset_outputs got=%h/%h/%b/%b want=0", quotient, remainder, div_by_zero, overflow);
        else pass_cnt++;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got=%b want=1", in_ready); else pass_cnt++;
    endtask

    task automatic test_normal();
        int lat;
        logic [31:0] dd [5] = '{32'h0000_0064, 32'hFFFE_0001, 32'h0000_FFFF, 32'h7FFF_FFFF, 32'h0000_0005};
        logic [15:0] dv [5] = '{16'h0007, 16'hFFFF, 16'h0100, 16'h8000, 16'h0009};
        logic [15:0] eq [5] = '{16'h000E, 16'hFFFF, 16'h00FF, 16'hFFFF, 16'h0000};
        logic [15:0] er [5] = '{16'h0002, 16'h0000, 16'h00FF, 16'h7FFF, 16'h0005};
        for (int i = 0; i < 5; i++) begin
            start_op(dd[i], dv[i]);
            wait_result(lat);
            total_cnt++;
            if (lat !== NLAT) $display("FAIL normal%0d_latency got=%0d want=%0d", i, lat, NLAT); else pass_cnt++;
            total_cnt++;
            if ({quotient, remainder, div_by_zero, overflow} !== {eq[i], er[i], 2'b00})
                $display("FAIL normal%0d_result got=%h/%h/%b/%b want=%h/%h/0/0",
                         i, quotient, remainder, div_by_zero, overflow, eq[i], er[i]);
            else pass_cnt++;
            retire();
        end
    endtask

    task automatic test_errors();
        int lat;
        logic [31:0] dd [3] = '{32'h1234_5678, 32'h0001_0000, 32'h0000_0000};
        logic [15:0] dv [3] = '{16'h0000, 16'h0001, 16'h0000};
        logic [15:0] er [3] = '{16'h5678, 16'h0000, 16'h0000};
        logic [1:0]  ef [3] = '{2'b10, 2'b01, 2'b10};
        for (int i = 0; i < 3; i++) begin
            start_op(dd[i], dv[i]);
            wait_result(lat);
            total_cnt++;
            if (lat !== 1) $display("FAIL err%0d_latency got=%0d want=1", i, lat); else pass_cnt++;
            total_cnt++;
            if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, er[i], ef[i]})
                $display("FAIL err%0d_result got=%h/%h/%b/%b want=ffff/%h/%b/%b",
                         i, quotient, remainder, div_by_zero, overflow, er[i], ef[i][1], ef[i][0]);
            else pass_cnt++;
            retire();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int seen;
        start_op(32'h0000_0064, 16'h0007);
        wait_result(lat);
        total_cnt++;
        if (lat !== NLAT) $display("FAIL bp_latency got=%0d want=%0d", lat, NLAT); else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            dividend = 32'h0000_0010;
            divisor  = 16'h0001;
            @(posedge clk);
            #1;
            total_cnt++;
            if ({out_valid, in_ready, quotient, remainder} !== {1'b1, 1'b0, 16'h000E, 16'h0002})
                $display("FAIL bp_hold%0d got=%b/%b/%h/%h want=1/0/000e/0002",
                         i, out_valid, in_ready, quotient, remainder);
            else pass_cnt++;
        end
        // in_valid stays high across the retiring edge; it must not be taken there.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL bp_retire_out_valid got=%b want=0", out_valid); else pass_cnt++;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_retire_in_ready got=%b want=1", in_ready); else pass_cnt++;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL bp_no_extra_op got=%0d busy cycles want=0", seen); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen;
        start_op(32'hFFFE_0001, 16'hFFFF);
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({out_valid, in_ready, quotient, remainder, div_by_zero, overflow} !== 36'h0)
            $display("FAIL midrst_state got=%b/%b/%h/%h/%b/%b want=all 0",
                     out_valid, in_ready, quotient, remainder, div_by_zero, overflow);
        else pass_cnt++;
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total_cnt++;
        if (seen !== 0) $display("FAIL midrst_no_result got=%0d valid cycles want=0", seen); else pass_cnt++;
        start_op(32'h0000_0064, 16'h0007);
        wait_result(lat);
        total_cnt++;
        if (lat !== NLAT) $display("FAIL midrst_latency got=%0d want=%0d", lat, NLAT); else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_by_zero, overflow} !== {16'h000E, 16'h0002, 2'b00})
            $display("FAIL midrst_result got=%h/%h/%b/%b want=000e/0002/0/0",
                     quotient, remainder, div_by_zero, overflow);
        else pass_cnt++;
        retire();
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        int lat;
        is_signed = 1'b1;
        start_op(32'hFFFF_FF9C, 16'h0007);
        wait_result(lat);
        total_cnt++;
        if (lat !== 18) $display("FAIL signed_latency got=%0d want=18", lat); else pass_cnt++;
        total_cnt++;
        if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFF2, 16'hFFFE, 2'b00})
            $display("FAIL signed_result got=%h/%h/%b/%b want=fff2/fffe/0/0",
                     quotient, remainder, div_by_zero, overflow);
        else pass_cnt++;
        retire();
        start_op(32'hC000_0000, 16'h0001);
        wait_result(lat);
        total_cnt++;
        if ({quotient, remainder, div_by_zero, overflow} !== {16'hFFFF, 16'h0000, 2'b01})
            $display("FAIL signed_ovf got=%h/%h/%b/%b want=ffff/0000/0/1",
                     quotient, remainder, div_by_zero, overflow);
        else pass_cnt++;
        retire();
        is_signed = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_normal();
        test_errors();
        test_backpressure();
        test_reset_mid();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
